// File: rtl/board_display_ctrl.sv
// Shadow-buffered 2048 board display controller: arbitrates engine/spawner writes and commits at LED frame boundaries.
// Optional spawned-tile blink is enabled by defining BOARD_BLINK_EN.
module board_display_ctrl #(
    parameter int BLINK_FRAMES = 8,
    parameter int BLINK_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_sync,
    input  logic        a_req,
    input  logic [63:0] a_board,
    output logic        a_ack,
    input  logic        b_req,
    input  logic [3:0]  b_idx,
    input  logic [3:0]  b_val,
    output logic        b_ack,
    output logic [63:0] mat_flat,
    output logic        pending
);

    // Out-of-range blink settings blank the display so a bad build is obvious on the panel.
    localparam logic CFG_BAD = (BLINK_FRAMES < 1) || (BLINK_FRAMES > 255) ||
                               (BLINK_CYCLES < 1) || (BLINK_CYCLES > 7);

    logic [63:0] shadow;
    logic [63:0] active;
    logic        dirty;
    logic        last_grant;
    logic        a_mask;
    logic        b_mask;

    logic        a_elig;
    logic        b_elig;
    logic        grant_a;
    logic        grant_b;
    logic        commit;
    logic [15:0] hide_tile;

    always_comb begin
        a_elig  = a_req & ~a_mask;
        b_elig  = b_req & ~b_mask;
        grant_a = a_elig & (~b_elig | last_grant);
        grant_b = b_elig & (~a_elig | ~last_grant);
        commit  = frame_sync & dirty;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow     <= '0;
            active     <= '0;
            dirty      <= 1'b0;
            last_grant <= 1'b1;
            a_mask     <= 1'b0;
            b_mask     <= 1'b0;
            a_ack      <= 1'b0;
            b_ack      <= 1'b0;
        end else begin
            a_ack  <= grant_a;
            b_ack  <= grant_b;
            // The mask covers the ack cycle, while the requester is still holding req.
            a_mask <= grant_a;
            b_mask <= grant_b;
            if (grant_a) begin
                shadow     <= a_board;
                last_grant <= 1'b0;
            end else if (grant_b) begin
                shadow[{b_idx, 2'b00} +: 4] <= b_val;
                last_grant <= 1'b1;
            end
            if (commit)
                active <= shadow;
            dirty <= grant_a | grant_b | (dirty & ~frame_sync);
        end
    end

`ifdef BOARD_BLINK_EN
    localparam logic [3:0] TOGGLES_INIT = 4'(2 * BLINK_CYCLES);
    localparam logic [7:0] FCNT_LAST    = 8'(BLINK_FRAMES - 1);

    logic [3:0] spawn_idx;
    logic [3:0] blink_idx;
    logic       blink_pend;
    logic [3:0] toggles;
    logic [7:0] fcnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            spawn_idx  <= '0;
            blink_idx  <= '0;
            blink_pend <= 1'b0;
            toggles    <= '0;
            fcnt       <= '0;
        end else begin
            if (grant_b)
                spawn_idx <= b_idx;
            if (grant_a) begin
                blink_pend <= 1'b0;
                toggles    <= '0;
            end else if (commit && !grant_b && blink_pend) begin
                // Spawn just became visible: restart the sequence on it.
                blink_idx  <= spawn_idx;
                toggles    <= TOGGLES_INIT;
                fcnt       <= '0;
                blink_pend <= 1'b0;
            end else begin
                if (grant_b)
                    blink_pend <= 1'b1;
                if (frame_sync && toggles != 4'd0) begin
                    if (fcnt == FCNT_LAST) begin
                        fcnt    <= '0;
                        toggles <= toggles - 4'd1;
                    end else begin
                        fcnt <= fcnt + 8'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        hide_tile = '0;
        if (toggles != 4'd0 && !toggles[0])
            hide_tile = 16'b1 << blink_idx;
    end
`else
    always_comb begin
        hide_tile = '0;
    end
`endif

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_tile
            assign mat_flat[4*gi +: 4] = (hide_tile[gi] | CFG_BAD) ? 4'h0 : active[4*gi +: 4];
        end
    endgenerate

    assign pending = dirty;

endmodule

// File: tb/tb_board_display_ctrl.sv
// Self-checking bench for board_display_ctrl: displayed boards are queued when frame_sync is driven
// and compared one cycle later by a monitor; handshakes are checked inline.
module tb_board_display_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        frame_sync = 1'b0;
    logic        a_req = 1'b0;
    logic [63:0] a_board = '0;
    logic        a_ack;
    logic        b_req = 1'b0;
    logic [3:0]  b_idx = '0;
    logic [3:0]  b_val = '0;
    logic        b_ack;
    logic [63:0] mat_flat;
    logic        pending;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] exp_q[$];
    logic        sync_seen = 1'b0;

`ifdef BOARD_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    board_display_ctrl #(
        .BLINK_FRAMES(2),
        .BLINK_CYCLES(1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_sync (frame_sync),
        .a_req      (a_req),
        .a_board    (a_board),
        .a_ack      (a_ack),
        .b_req      (b_req),
        .b_idx      (b_idx),
        .b_val      (b_val),
        .b_ack      (b_ack),
        .mat_flat   (mat_flat),
        .pending    (pending)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] set_tile(input logic [63:0] brd, input int idx, input logic [3:0] v);
        logic [63:0] r;
        r = brd;
        r[4*idx +: 4] = v;
        return r;
    endfunction

    // A freshly committed spawn is hidden during its first blink phase.
    function automatic logic [63:0] hide(input logic [63:0] brd, input int idx);
        return BLINK_ON ? set_tile(brd, idx, 4'h0) : brd;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_sync(input logic [63:0] exp);
        frame_sync = 1'b1;
        exp_q.push_back(exp);
        tick();
        frame_sync = 1'b0;
        tick();
        $display("txn sync expect_display=%h", exp);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("reset_mat", mat_flat, 64'd0);
        $display("txn reset");
    endtask

    always @(posedge clk) sync_seen <= frame_sync & reset;

    // The board displayed in the cycle after a frame_sync must match the queued expectation.
    always @(negedge clk) begin
        if (sync_seen) begin
            check("sb_queue_len", 64'(exp_q.size()), 64'd1);
            if (exp_q.size() > 0)
                check("sb_display", mat_flat, exp_q.pop_front());
        end
    end

    initial begin
        // Reset and idle
        repeat (3) tick();
        reset = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            check("idle_mat", mat_flat, 64'd0);
            check("idle_flags", 64'({a_ack, b_ack, pending}), 64'd0);
        end
        $display("txn idle 100 cycles");

        // Engine write, commit ten cycles later
        a_board = 64'h0000_0000_0000_0021;
        a_req = 1'b1;
        tick();
        check("eng_ack", 64'(a_ack), 64'd1);
        check("eng_pending", 64'(pending), 64'd1);
        tick();
        a_req = 1'b0;
        check("eng_ack_once", 64'(a_ack), 64'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("eng_pend_hold", 64'(pending), 64'd1);
            check("eng_not_shown", mat_flat, 64'd0);
        end
        $display("txn engine write board=%h", a_board);
        do_sync(64'h0000_0000_0000_0021);
        check("eng_committed", 64'(pending), 64'd0);

        // Tie with A granted last: B wins, then A overwrites the whole board
        a_board = 64'h0000_0000_0000_0444;
        b_idx = 4'd2;
        b_val = 4'd6;
        a_req = 1'b1;
        b_req = 1'b1;
        tick();
        check("rr_b_first", 64'({a_ack, b_ack}), 64'b01);
        tick();
        b_req = 1'b0;
        check("rr_a_second", 64'({a_ack, b_ack}), 64'b10);
        tick();
        a_req = 1'b0;
        check("rr_quiet", 64'({a_ack, b_ack}), 64'b00);
        $display("txn tie after A: B then A");
        do_sync(64'h0000_0000_0000_0444);

        // Tie right after reset: A wins the first tie
        do_reset();
        a_board = 64'h0000_0000_0021_0000;
        b_idx = 4'd5;
        b_val = 4'd3;
        a_req = 1'b1;
        b_req = 1'b1;
        tick();
        check("tie_a_first", 64'({a_ack, b_ack}), 64'b10);
        tick();
        a_req = 1'b0;
        check("tie_b_second", 64'({a_ack, b_ack}), 64'b01);
        tick();
        b_req = 1'b0;
        check("tie_quiet", 64'({a_ack, b_ack}), 64'b00);
        repeat (3) tick();
        $display("txn tie after reset: A then B");
        do_sync(hide(64'h0000_0000_0031_0000, 5));

        // Spawner grant in the same cycle as frame_sync
        b_idx = 4'd9;
        b_val = 4'd7;
        b_req = 1'b1;
        frame_sync = 1'b1;
        exp_q.push_back(hide(64'h0000_0000_0031_0000, 5));
        tick();
        frame_sync = 1'b0;
        check("col_ack", 64'(b_ack), 64'd1);
        check("col_pending", 64'(pending), 64'd1);
        tick();
        b_req = 1'b0;
        check("col_pend_hold", 64'(pending), 64'd1);
        tick();
        $display("txn sync collision spawn idx=9 val=7");
        do_sync(hide(64'h0000_0070_0031_0000, 9));
        check("col_committed", 64'(pending), 64'd0);

        // Spawned tile blink (or immediate display when blink is not built)
        do_reset();
        b_idx = 4'd0;
        b_val = 4'd1;
        b_req = 1'b1;
        tick();
        check("blk_ack", 64'(b_ack), 64'd1);
        tick();
        b_req = 1'b0;
        tick();
        $display("txn spawn idx=0 val=1");
        do_sync(BLINK_ON ? 64'd0 : 64'd1);
        do_sync(BLINK_ON ? 64'd0 : 64'd1);
        do_sync(64'd1);
        do_sync(64'd1);
        do_sync(64'd1);

        // Reset while a write is uncommitted and b_req is still held
        b_idx = 4'd3;
        b_val = 4'd5;
        b_req = 1'b1;
        tick();
        check("rmo_dirty", 64'(pending), 64'd1);
        reset = 1'b0;
        #1;
        check("rmo_flags", 64'({a_ack, b_ack, pending}), 64'd0);
        check("rmo_mat", mat_flat, 64'd0);
        tick();
        tick();
        check("rmo_no_ack", 64'(b_ack), 64'd0);
        reset = 1'b1;
        tick();
        check("rmo_regrant", 64'({b_ack, pending}), 64'b11);
        check("rmo_mat_clear", mat_flat, 64'd0);
        tick();
        b_req = 1'b0;
        check("rmo_ack_once", 64'(b_ack), 64'd0);
        $display("txn reset mid-operation, held spawn regranted");
        do_sync(hide(64'h0000_0000_0000_5000, 3));

        tick();
        check("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
